tempsens_pwm_decoder: RTL and testbench

//  Receive end of the temperature-sensor PWM output: measures high time and

---
 rtl/tempsens_pwm_decoder.sv | 144 ++++++++++++++
 tb/tb_tempsens_pwm_decoder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/tempsens_pwm_decoder.sv
// tempsens_pwm_decoder
// Receive end of the temperature-sensor PWM link. Measures the high time and the
// rise-to-rise period of an asynchronous PWM line in clock cycles. Each accepted
// period is published with a one-cycle valid strobe. Periods that are too short
// are dropped and flagged. A line with no rising edge for too long is flagged
// as stuck.
//
// Ports:
//   clk_i          system clock
//   reset_i        synchronous, active-high reset
//   pwm_i          PWM line, asynchronous to clk_i
//   meas_high_o    high cycles in the last accepted period
//   meas_period_o  length of the last accepted period, rise to rise
//   meas_valid_o   one-cycle pulse: meas_* were just updated
//   err_short_o    one-cycle pulse: a period shorter than MIN_PERIOD was discarded
//   stuck_o        no rising edge seen for TIMEOUT cycles
//   stuck_level_o  synchronized line level captured on entry to the stuck state
module tempsens_pwm_decoder #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MIN_PERIOD  = 4,
    parameter int unsigned TIMEOUT     = 65535
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             pwm_i,
    output logic [CNT_W-1:0] meas_high_o,
    output logic [CNT_W-1:0] meas_period_o,
    output logic             meas_valid_o,
    output logic             err_short_o,
    output logic             stuck_o,
    output logic             stuck_level_o
);

    localparam logic [1:0] StIdle  = 2'd0;  // no reference rising edge yet
    localparam logic [1:0] StHigh  = 2'd1;
    localparam logic [1:0] StLow   = 2'd2;
    localparam logic [1:0] StStuck = 2'd3;

    localparam logic [CNT_W-1:0] CntMax     = '1;
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] MinPerVal  = CNT_W'(MIN_PERIOD);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pwm_s;
    logic                   pwm_d_q;
    logic                   rise;
    logic                   fall;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic [CNT_W-1:0] meas_high_q, meas_high_d;
    logic [CNT_W-1:0] meas_period_q, meas_period_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             stuck_q, stuck_d;
    logic             stuck_level_q, stuck_level_d;

    assign pwm_s = sync_q[SYNC_STAGES-1];
    assign rise  = pwm_s & ~pwm_d_q;
    assign fall  = ~pwm_s & pwm_d_q;

    always_comb begin
        state_d       = state_q;
        per_d         = per_q;
        hi_d          = hi_q;
        meas_high_d   = meas_high_q;
        meas_period_d = meas_period_q;
        valid_d       = 1'b0;
        err_d         = 1'b0;
        stuck_d       = stuck_q;
        stuck_level_d = stuck_level_q;

        // Free-running counts; both saturate rather than wrap.
        if (state_q != StStuck && per_q != CntMax) begin
            per_d = per_q + CntOne;
        end
        if ((state_q == StHigh || state_q == StLow) && pwm_s && hi_q != CntMax) begin
            hi_d = hi_q + CntOne;
        end

        // A rise takes priority over a timeout that happens in the same cycle.
        if (rise) begin
            if (state_q == StLow) begin
                if (per_q >= MinPerVal) begin
                    meas_period_d = per_q;
                    meas_high_d   = hi_q;
                    valid_d       = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            // The rise cycle itself has the line high, so it counts as 1 for both.
            per_d   = CntOne;
            hi_d    = CntOne;
            state_d = StHigh;
            stuck_d = 1'b0;
        end else if (state_q != StStuck && per_q == TimeoutVal) begin
            state_d       = StStuck;
            stuck_d       = 1'b1;
            stuck_level_d = pwm_s;
        end else if (state_q == StHigh && fall) begin
            state_d = StLow;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q        <= '0;
            pwm_d_q       <= 1'b0;
            state_q       <= StIdle;
            per_q         <= '0;
            hi_q          <= '0;
            meas_high_q   <= '0;
            meas_period_q <= '0;
            valid_q       <= 1'b0;
            err_q         <= 1'b0;
            stuck_q       <= 1'b0;
            stuck_level_q <= 1'b0;
        end else begin
            sync_q        <= {sync_q[SYNC_STAGES-2:0], pwm_i};
            pwm_d_q       <= pwm_s;
            state_q       <= state_d;
            per_q         <= per_d;
            hi_q          <= hi_d;
            meas_high_q   <= meas_high_d;
            meas_period_q <= meas_period_d;
            valid_q       <= valid_d;
            err_q         <= err_d;
            stuck_q       <= stuck_d;
            stuck_level_q <= stuck_level_d;
        end
    end

    assign meas_high_o   = meas_high_q;
    assign meas_period_o = meas_period_q;
    assign meas_valid_o  = valid_q;
    assign err_short_o   = err_q;
    assign stuck_o       = stuck_q;
    assign stuck_level_o = stuck_level_q;

endmodule

// File: tb/tb_tempsens_pwm_decoder.sv
// Directed bench for tempsens_pwm_decoder (CNT_W=16, SYNC_STAGES=2, MIN_PERIOD=4,
// TIMEOUT=1000). Inputs are driven and outputs sampled on the falling clock edge.
// A rise driven at negedge index d shows its strobe in the sample at index d+3.
module tb_tempsens_pwm_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pwm = 1'b0;
    logic [15:0] meas_high;
    logic [15:0] meas_period;
    logic        meas_valid;
    logic        err_short;
    logic        stuck;
    logic        stuck_level;

    tempsens_pwm_decoder #(
        .CNT_W      (16),
        .SYNC_STAGES(2),
        .MIN_PERIOD (4),
        .TIMEOUT    (1000)
    ) dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .pwm_i        (pwm),
        .meas_high_o  (meas_high),
        .meas_period_o(meas_period),
        .meas_valid_o (meas_valid),
        .err_short_o  (err_short),
        .stuck_o      (stuck),
        .stuck_level_o(stuck_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_cnt, err_cnt, both_cnt;
    int first_valid_idx, last_valid_idx, last_err_idx;
    int last_high, last_period, err_high, err_period;
    int stuck_rise_idx, stuck_fall_idx;
    logic stuck_prev = 1'b0;
    int base, d0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        valid_cnt       = 0;
        err_cnt         = 0;
        first_valid_idx = -1;
        last_valid_idx  = -1;
        last_err_idx    = -1;
        last_high       = -1;
        last_period     = -1;
        err_high        = -1;
        err_period      = -1;
        stuck_rise_idx  = -1;
        stuck_fall_idx  = -1;
    endtask

    // One cycle: sample outputs at the falling edge, then drive the next PWM level.
    task automatic tick(input logic v);
        @(negedge clk);
        if (meas_valid) begin
            if (valid_cnt == 0) first_valid_idx = cyc;
            valid_cnt++;
            last_valid_idx = cyc;
            last_high      = int'(meas_high);
            last_period    = int'(meas_period);
        end
        if (err_short) begin
            err_cnt++;
            last_err_idx = cyc;
            err_high     = int'(meas_high);
            err_period   = int'(meas_period);
        end
        if (meas_valid && err_short) both_cnt++;
        if (stuck && !stuck_prev) stuck_rise_idx = cyc;
        if (!stuck && stuck_prev) stuck_fall_idx = cyc;
        stuck_prev = stuck;
        pwm = v;
        cyc++;
    endtask

    task automatic run_period(input int hi, input int lo);
        for (int i = 0; i < hi + lo; i++) tick(i < hi);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_high"}, int'(meas_high), 0);
        check({tag, "_period"}, int'(meas_period), 0);
        check({tag, "_valid"}, int'(meas_valid), 0);
        check({tag, "_err"}, int'(err_short), 0);
        check({tag, "_stuck"}, int'(stuck), 0);
        check({tag, "_level"}, int'(stuck_level), 0);
    endtask

    initial begin
        both_cnt = 0;
        clear_counts();

        // Reset state.
        rst = 1'b1;
        repeat (3) tick(1'b0);
        check_all_zero("reset");

        // Line low from reset: stuck after the timeout, level 0, nothing published.
        rst = 1'b0;
        d0  = cyc - 1;
        clear_counts();
        repeat (1005) tick(1'b0);
        check("t5_stuck_idx", stuck_rise_idx, d0 + 1001);
        check("t5_stuck", int'(stuck), 1);
        check("t5_level", int'(stuck_level), 0);
        check("t5_valid_cnt", valid_cnt, 0);

        // Period 100, high 30: nothing at the first rise, then every 100 cycles.
        rst = 1'b1;
        repeat (3) tick(1'b0);
        check("t1_reset_stuck", int'(stuck), 0);
        rst = 1'b0;
        repeat (5) tick(1'b0);
        clear_counts();
        base = cyc;
        repeat (4) run_period(30, 70);
        check("t1_valid_cnt", valid_cnt, 3);
        check("t1_first_valid", first_valid_idx, base + 103);
        check("t1_last_valid", last_valid_idx, base + 303);
        check("t1_period", last_period, 100);
        check("t1_high", last_high, 30);
        check("t1_err_cnt", err_cnt, 0);

        // Duty change to 70 at a period boundary.
        clear_counts();
        base = cyc;
        repeat (2) run_period(70, 30);
        check("t2_valid_cnt", valid_cnt, 2);
        check("t2_last_valid", last_valid_idx, base + 103);
        check("t2_high", last_high, 70);
        check("t2_out_high", int'(meas_high), 70);
        check("t2_out_period", int'(meas_period), 100);

        // Glitch pair of period 2, then a clean period.
        clear_counts();
        base = cyc;
        run_period(1, 1);
        run_period(70, 30);
        run_period(70, 30);
        check("t3_err_cnt", err_cnt, 1);
        check("t3_err_idx", last_err_idx, base + 5);
        check("t3_err_period", err_period, 100);
        check("t3_err_high", err_high, 70);
        check("t3_valid_cnt", valid_cnt, 2);
        check("t3_last_valid", last_valid_idx, base + 105);
        check("t3_period", last_period, 100);
        check("t3_high", last_high, 70);

        // Line held high: stuck exactly 1000 cycles after the last rise.
        clear_counts();
        base = cyc;
        repeat (1200) tick(1'b1);
        check("t4_stuck_idx", stuck_rise_idx, base + 1003);
        check("t4_stuck", int'(stuck), 1);
        check("t4_level", int'(stuck_level), 1);
        check("t4_valid_cnt", valid_cnt, 1);
        repeat (50) tick(1'b0);
        check("t4_stuck_after_fall", int'(stuck), 1);
        check("t4_level_hold", int'(stuck_level), 1);
        clear_counts();
        base = cyc;
        run_period(30, 70);
        check("t4_restart_valid_cnt", valid_cnt, 0);
        check("t4_stuck_clear_idx", stuck_fall_idx, base + 3);
        run_period(30, 70);
        check("t4_resume_valid_cnt", valid_cnt, 1);
        check("t4_resume_valid_idx", last_valid_idx, base + 103);
        check("t4_resume_high", last_high, 30);
        check("t4_resume_period", last_period, 100);

        // Reset in the middle of a period.
        run_period(30, 70);
        repeat (30) tick(1'b1);
        repeat (20) tick(1'b0);
        rst = 1'b1;
        repeat (3) tick(1'b0);
        check_all_zero("t6_reset");
        rst = 1'b0;
        clear_counts();
        repeat (20) tick(1'b0);
        base = cyc;
        run_period(30, 70);
        check("t6_first_valid_cnt", valid_cnt, 0);
        check("t6_first_period_out", int'(meas_period), 0);
        run_period(30, 70);
        check("t6_valid_cnt", valid_cnt, 1);
        check("t6_valid_idx", last_valid_idx, base + 103);
        check("t6_period", last_period, 100);
        check("t6_high", last_high, 30);

        check("valid_err_overlap", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
